uart_rx_ctrl: RTL and testbench

- Sequencing controller for the UART receiver.
- Detects a start bit on the synchronized serial line and runs oversampling edge and bit counters from the latched prescale value.
- Issues one-cycle enables to the data sampler, deserializer, start, parity and stop checkers in frame order, then raises `data_valid` only for error-free frames.
- Sits between the RX line synchronizer and the receiver checker/deserializer blocks.

---
 rtl/uart_rx_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for the UART receiver.
// Detects the start bit on the synchronized RX line, runs the oversampling
// edge/bit counters from the prescale value latched at start detect, and
// issues one-cycle enables to the sampler, deserializer and the start,
// parity and stop checkers in frame order. data_valid pulses only for
// frames whose stop and parity checks passed.
// Optional feature: define UART_RX_BREAK_DET_EN to add the break_det port
// (all-zero data with a stop error reports a break instead of a drop).
module uart_rx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      deser_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
`ifdef UART_RX_BREAK_DET_EN
  output logic                      break_det,
`endif
  output logic                      data_valid
);

  localparam int         PW            = PRESCALE_WIDTH;
  localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] p_lat, p_lat_nxt;
  logic          par_en_lat, par_en_lat_nxt;
  logic          par_flag, par_flag_nxt;
  logic [PW-1:0] edge_nxt;
  logic [3:0]    bit_nxt;
  logic [PW-1:0] p_last, mid, mid_eval, mid_nxt;
  logic          wrap, at_eval;
  logic          samp_nxt, strt_nxt, deser_nxt, par_chk_nxt, stp_chk_nxt;
  logic          valid_nxt;
`ifdef UART_RX_BREAK_DET_EN
  logic          zero_flag, zero_flag_nxt;
  logic          break_nxt;
`endif

  // Timing points of the current bit from the latched prescale; a zero
  // prescale clamps the last edge to 0 so the counters still advance.
  always_comb begin
    p_last   = (p_lat == '0) ? '0 : p_lat - PW'(1);
    mid      = (p_lat >> 1) + PW'(2);
    mid_eval = mid + PW'(1);
    wrap     = (edge_cnt >= p_last);
    at_eval  = (edge_cnt == mid_eval);
  end

  // Next-state, counter and latch logic; STOP also leaves on wrap so an
  // illegal prescale whose mid point never occurs still returns to IDLE.
  always_comb begin
    state_nxt      = state;
    p_lat_nxt      = p_lat;
    par_en_lat_nxt = par_en_lat;
    par_flag_nxt   = par_flag;
    valid_nxt      = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    zero_flag_nxt  = zero_flag;
    break_nxt      = 1'b0;
`endif
    if (wrap) begin
      edge_nxt = '0;
      bit_nxt  = bit_cnt + 4'd1;
    end else begin
      edge_nxt = edge_cnt + PW'(1);
      bit_nxt  = bit_cnt;
    end
    case (state)
      IDLE: begin
        edge_nxt = '0;
        bit_nxt  = '0;
        if (!RX_IN) begin
          state_nxt      = START;
          edge_nxt       = PW'(1);
          p_lat_nxt      = PRESCALE;
          par_en_lat_nxt = PAR_EN;
          par_flag_nxt   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          zero_flag_nxt  = 1'b1;
`endif
        end
      end
      START: begin
        if (at_eval && strt_glitch) state_nxt = IDLE;
        else if (wrap)              state_nxt = DATA;
      end
      DATA: begin
`ifdef UART_RX_BREAK_DET_EN
        if ((edge_cnt == mid) && RX_IN) zero_flag_nxt = 1'b0;
`endif
        if (wrap && (bit_cnt >= LAST_DATA_BIT))
          state_nxt = par_en_lat ? PARITY : STOP;
      end
      PARITY: begin
        if (at_eval) par_flag_nxt = par_flag | par_err;
        if (wrap)    state_nxt    = STOP;
      end
      STOP: begin
        if (at_eval) begin
          state_nxt = IDLE;
`ifdef UART_RX_BREAK_DET_EN
          if (zero_flag && stp_err)        break_nxt = 1'b1;
          else if (!stp_err && !par_flag)  valid_nxt = 1'b1;
`else
          if (!stp_err && !par_flag)       valid_nxt = 1'b1;
`endif
        end else if (wrap) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == IDLE) begin
      edge_nxt = '0;
      bit_nxt  = '0;
    end
  end

  // Strobes are decoded from the next state/edge so the registered copy
  // is high exactly in the cycle whose edge_cnt equals the mid point.
  always_comb begin
    mid_nxt     = (p_lat_nxt >> 1) + PW'(2);
    samp_nxt    = (state_nxt != IDLE);
    strt_nxt    = (state_nxt == START)  && (edge_nxt == mid_nxt);
    deser_nxt   = (state_nxt == DATA)   && (edge_nxt == mid_nxt);
    par_chk_nxt = (state_nxt == PARITY) && (edge_nxt == mid_nxt);
    stp_chk_nxt = (state_nxt == STOP)   && (edge_nxt == mid_nxt);
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      p_lat       <= '0;
      par_en_lat  <= 1'b0;
      par_flag    <= 1'b0;
      dat_samp_en <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      zero_flag   <= 1'b0;
      break_det   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      edge_cnt    <= edge_nxt;
      bit_cnt     <= bit_nxt;
      p_lat       <= p_lat_nxt;
      par_en_lat  <= par_en_lat_nxt;
      par_flag    <= par_flag_nxt;
      dat_samp_en <= samp_nxt;
      strt_chk_en <= strt_nxt;
      deser_en    <= deser_nxt;
      par_chk_en  <= par_chk_nxt;
      stp_chk_en  <= stp_chk_nxt;
      data_valid  <= valid_nxt;
`ifdef UART_RX_BREAK_DET_EN
      zero_flag   <= zero_flag_nxt;
      break_det   <= break_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed frames; expected strobe events and
// per-cycle counter states are queued by the stimulus and checked by a
// separate negedge monitor. Covers UART_RX_BREAK_DET_EN when defined.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic       data_valid;
  logic       brk_v;
`ifdef UART_RX_BREAK_DET_EN
  logic       break_det;
  assign brk_v = break_det;
`else
  assign brk_v = 1'b0;
`endif

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_IN(RX_IN),
    .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN),
    .strt_glitch(strt_glitch),
    .par_err(par_err),
    .stp_err(stp_err),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en),
    .deser_en(deser_en),
    .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en),
`ifdef UART_RX_BREAK_DET_EN
    .break_det(break_det),
`endif
    .data_valid(data_valid)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  typedef struct {
    int         at;
    logic [5:0] ec;
    logic [3:0] bc;
    logic       samp;
    logic       quiet;
  } st_t;

  ev_t   exp_q[$];
  st_t   st_q[$];
  int    total = 0;
  int    bad = 0;
  bit    done = 1'b0;
  string kname[6] = '{"strt_chk_en", "deser_en", "par_chk_en", "stp_chk_en", "data_valid", "break_det"};

  task automatic push_st(input int at, input int ec, input int bc, input bit samp, input bit quiet);
    st_t s;
    s.at = at; s.ec = 6'(ec); s.bc = 4'(bc); s.samp = samp; s.quiet = quiet;
    st_q.push_back(s);
  endtask

  task automatic push_ev(input int kind, input int base, input int rel, input int abort);
    ev_t e;
    if (abort < 0 || rel < abort) begin
      e.kind = kind; e.at = base + rel;
      exp_q.push_back(e);
    end
  endtask

  // One frame starting now (called #1 after a posedge); returns #1 after the
  // posedge of the cycle following the last driven cycle.
  task automatic run_frame(input logic [7:0] data, input int p, input bit pen,
                           input bit glitch, input int glen, input bit perr,
                           input bit serr, input int abort);
    int  base, m, s, last, bi;
    bit  brk;
    logic v;
    base = cyc;
    m    = p / 2 + 2;
    s    = pen ? 10 : 9;
    last = glitch ? m + 1 : s * p + m + 1;
    if (abort >= 0) last = abort - 1;
`ifdef UART_RX_BREAK_DET_EN
    brk = (data == 8'h00) && serr;
`else
    brk = 1'b0;
`endif
    push_ev(0, base, m, abort);
    if (!glitch) begin
      for (int k = 1; k <= 8; k++) push_ev(1, base, k * p + m, abort);
      if (pen) push_ev(2, base, 9 * p + m, abort);
      push_ev(3, base, s * p + m, abort);
      if (brk)              push_ev(5, base, s * p + m + 2, abort);
      else if (!perr && !serr) push_ev(4, base, s * p + m + 2, abort);
    end
    for (int r = 0; r <= last; r++) begin
      bi = r / p;
      if (bi == 0)                 v = glitch ? (r >= glen) : 1'b0;
      else if (bi <= 8)            v = data[bi-1];
      else if (pen && bi == 9)     v = ^data;
      else                         v = !serr;
      RX_IN       = v;
      PRESCALE    = (r == 0) ? 6'(p) : ((p == 8) ? 6'd32 : 6'd8);
      PAR_EN      = (r == 0) ? pen : !pen;
      strt_glitch = glitch && (r == m + 1);
      par_err     = perr && pen && (r == 9 * p + m + 1);
      stp_err     = serr && (r == s * p + m + 1);
      push_st(base + r, r % p, r / p, r >= 1, 1'b0);
      @(posedge CLK); #1;
    end
    RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      push_st(cyc, 0, 0, 1'b0, 1'b0);
      @(posedge CLK); #1;
    end
  endtask

  // Monitor: pops expected strobe events and counter states and compares.
  logic [5:0] pulses_v;
  ev_t        ev_v;
  st_t        st_v;
  always @(negedge CLK) begin
    pulses_v = {brk_v, data_valid, stp_chk_en, par_chk_en, deser_en, strt_chk_en};
    for (int k = 0; k < 6; k++) begin
      if (pulses_v[k]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s: pulse at cycle %0d, required no pulse", kname[k], cyc);
        end else begin
          ev_v = exp_q.pop_front();
          if (ev_v.kind != k || ev_v.at != cyc) begin
            bad++;
            $display("FAIL %s: pulse at cycle %0d, required %s at cycle %0d",
                     kname[k], cyc, kname[ev_v.kind], ev_v.at);
          end
        end
      end
    end
    while (st_q.size() > 0 && st_q[0].at <= cyc) begin
      st_v = st_q.pop_front();
      total++;
      if (st_v.at != cyc || edge_cnt != st_v.ec || bit_cnt != st_v.bc ||
          dat_samp_en != st_v.samp || (st_v.quiet && pulses_v != 6'd0)) begin
        bad++;
        $display("FAIL state@%0d: edge=%0d bit=%0d samp=%0d pulses=%b, required edge=%0d bit=%0d samp=%0d quiet=%0d (cycle %0d)",
                 st_v.at, edge_cnt, bit_cnt, dat_samp_en, pulses_v,
                 st_v.ec, st_v.bc, st_v.samp, st_v.quiet, cyc);
      end
    end
    if (done) begin
      total++;
      if (exp_q.size() != 0 || st_q.size() != 0) begin
        bad++;
        $display("FAIL leftover: events=%0d states=%0d still pending, required 0", exp_q.size(), st_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    push_st(cyc, 0, 0, 1'b0, 1'b1);
    @(negedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    idle_gap(2);
    // good frame, no parity, P=8
    run_frame(8'hA5, 8, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1);
    idle_gap(3);
    // good frame, parity, P=16
    run_frame(8'h3C, 16, 1'b1, 1'b0, 0, 1'b0, 1'b0, -1);
    idle_gap(3);
    // parity error
    run_frame(8'h3C, 16, 1'b1, 1'b0, 0, 1'b1, 1'b0, -1);
    idle_gap(3);
    // start glitch, line low for 2 cycles
    run_frame(8'h00, 8, 1'b0, 1'b1, 2, 1'b0, 1'b0, -1);
    idle_gap(3);
    // back-to-back frames
    run_frame(8'h81, 8, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1);
    run_frame(8'h7E, 8, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1);
    idle_gap(3);
    // reset at cycle 30 of a frame
    run_frame(8'hC3, 8, 1'b0, 1'b0, 0, 1'b0, 1'b0, 30);
    RST = 1'b0;
    push_st(cyc, 0, 0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    push_st(cyc, 0, 0, 1'b0, 1'b1);
    @(posedge CLK); #1;
    RST = 1'b1;
    idle_gap(2);
    // normal frame after reset, P=32
    run_frame(8'h5A, 32, 1'b0, 1'b0, 0, 1'b0, 1'b0, -1);
    idle_gap(3);
    // all-zero data with stop error (break when enabled, else dropped)
    run_frame(8'h00, 8, 1'b0, 1'b0, 0, 1'b0, 1'b1, -1);
    idle_gap(2);
    // non-zero data with stop error and parity: dropped
    run_frame(8'h96, 8, 1'b1, 1'b0, 0, 1'b0, 1'b1, -1);
    idle_gap(3);
    done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached without completion, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
